// File: rtl/cpu_ex_muldiv_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
// Covers the operation handshake, the HI/LO read port and the completion pulses.
interface cpu_ex_muldiv_if #(
    parameter int unsigned XLEN = 32
);
    logic            flush;
    logic            op_valid;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            op_ready;
    logic            busy;
    logic            rd_req;
    logic            rd_sel;
    logic [XLEN-1:0] rd_data;
    logic            stall_req;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic            done;
    logic            div_zero;

    modport master (
        output flush, op_valid, op, a, b, rd_req, rd_sel,
        input  op_ready, busy, rd_data, stall_req, hi, lo, done, div_zero
    );

    modport slave (
        input  flush, op_valid, op, a, b, rd_req, rd_sel,
        output op_ready, busy, rd_data, stall_req, hi, lo, done, div_zero
    );
endinterface

// File: rtl/cpu_ex_muldiv.sv
// EX-stage multiply/divide unit owning the HI/LO registers: fixed-latency multiply,
// restoring divide (one bit per cycle plus sign fixup), MTHI/MTLO and pipeline flush.
module cpu_ex_muldiv #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned MUL_LAT = 3
) (
    input logic                 clk,
    input logic                 clr_n,
    cpu_ex_muldiv_if.slave      bus
);
    localparam int unsigned CNT_W = $clog2(XLEN + 1);
    localparam int unsigned PRD_W = 2 * XLEN;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   opa_q, opa_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic              sgn_q, sgn_d;
    logic              q_neg_q, q_neg_d;
    logic              r_neg_q, r_neg_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic              done_q, done_d;
    logic              dz_q, dz_d;

    logic              accept;
    logic              div_signed;
    logic [PRD_W-1:0]  mul_a_ext;
    logic [PRD_W-1:0]  mul_b_ext;
    logic [PRD_W-1:0]  product;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;

    function automatic logic [XLEN-1:0] neg(input logic [XLEN-1:0] x);
        return ~x + XLEN'(1);
    endfunction

    // Sign- or zero-extend to full width so one unsigned multiply serves both MULT and MULTU
    assign mul_a_ext = sgn_q ? {{XLEN{opa_q[XLEN-1]}}, opa_q} : {{XLEN{1'b0}}, opa_q};
    assign mul_b_ext = sgn_q ? {{XLEN{opb_q[XLEN-1]}}, opb_q} : {{XLEN{1'b0}}, opb_q};
    assign product   = mul_a_ext * mul_b_ext;

    // Restoring step: opa_q shifts dividend bits out and quotient bits in
    assign div_shift = {rem_q, opa_q[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, opb_q};

    assign accept     = bus.op_valid && (state_q == S_IDLE) && !bus.flush;
    assign div_signed = (bus.op == OP_DIV);

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            rem_q   <= '0;
            sgn_q   <= 1'b0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            rem_q   <= rem_d;
            sgn_q   <= sgn_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        rem_d   = rem_q;
        sgn_d   = sgn_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dz_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (bus.op)
                        OP_MULT, OP_MULTU: begin
                            opa_d   = bus.a;
                            opb_d   = bus.b;
                            sgn_d   = (bus.op == OP_MULT);
                            cnt_d   = CNT_W'(MUL_LAT - 1);
                            state_d = S_MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            if (bus.b == '0) begin
                                lo_d   = '1;
                                hi_d   = bus.a;
                                done_d = 1'b1;
                                dz_d   = 1'b1;
                            end else begin
                                opa_d   = (div_signed && bus.a[XLEN-1]) ? neg(bus.a) : bus.a;
                                opb_d   = (div_signed && bus.b[XLEN-1]) ? neg(bus.b) : bus.b;
                                rem_d   = '0;
                                q_neg_d = div_signed && (bus.a[XLEN-1] ^ bus.b[XLEN-1]);
                                r_neg_d = div_signed && bus.a[XLEN-1];
                                cnt_d   = CNT_W'(XLEN);
                                state_d = S_DIV;
                            end
                        end
                        OP_MTHI: hi_d = bus.a;
                        OP_MTLO: lo_d = bus.a;
                        default: ;
                    endcase
                end
            end

            S_MUL: begin
                if (bus.flush) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    {hi_d, lo_d} = product;
                    done_d       = 1'b1;
                    state_d      = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            S_DIV: begin
                if (bus.flush) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (cnt_q != '0) begin
                    if (!div_diff[XLEN]) begin
                        rem_d = div_diff[XLEN-1:0];
                        opa_d = {opa_q[XLEN-2:0], 1'b1};
                    end else begin
                        rem_d = div_shift[XLEN-1:0];
                        opa_d = {opa_q[XLEN-2:0], 1'b0};
                    end
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    // Sign fixup cycle: magnitudes back to signed results
                    lo_d    = q_neg_q ? neg(opa_q) : opa_q;
                    hi_d    = r_neg_q ? neg(rem_q) : rem_q;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.op_ready  = (state_q == S_IDLE);
    assign bus.busy      = (state_q == S_MUL) || (state_q == S_DIV);
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
    assign bus.done      = done_q;
    assign bus.div_zero  = dz_q;
    assign bus.rd_data   = bus.rd_sel ? hi_q : lo_q;
    assign bus.stall_req = bus.rd_req && bus.busy;
endmodule

// File: tb/tb_cpu_ex_muldiv.sv
// Directed test of cpu_ex_muldiv (XLEN=32, MUL_LAT=3) with hand-computed results:
// multiply/divide values and latencies, divide by zero, stall, flush and mid-op reset.
module tb_cpu_ex_muldiv;
    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    logic clk;
    logic clr_n;
    int   n_chk;
    int   n_err;

    cpu_ex_muldiv_if #(.XLEN(32)) bus ();

    cpu_ex_muldiv #(.XLEN(32), .MUL_LAT(3)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single-edge register move (MTHI/MTLO); no completion pulse expected
    task automatic issue_mt(input logic [2:0] o, input logic [31:0] av);
        bus.op_valid = 1'b1;
        bus.op       = o;
        bus.a        = av;
        step();
        bus.op_valid = 1'b0;
        bus.op       = OP_NONE;
    endtask

    // Issue an op and wait for done; lat = edges after the accepting edge until done is seen
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] av,
                          input logic [31:0] bv, output int lat, output int busy_n,
                          output int stall_n);
        chk({tag, "_ready"}, 64'(bus.op_ready), 64'd1);
        bus.op_valid = 1'b1;
        bus.op       = o;
        bus.a        = av;
        bus.b        = bv;
        step();
        bus.op_valid = 1'b0;
        bus.op       = OP_NONE;
        lat     = 0;
        busy_n  = 0;
        stall_n = 0;
        while (bus.done !== 1'b1 && lat < 200) begin
            if (bus.busy === 1'b1)      busy_n++;
            if (bus.stall_req === 1'b1) stall_n++;
            step();
            lat++;
        end
        if (bus.done !== 1'b1) chk({tag, "_timeout"}, 64'(bus.done), 64'd1);
    endtask

    int lat, busy_n, stall_n, cnt;

    initial begin
        n_chk = 0;
        n_err = 0;
        clr_n = 1'b0;
        bus.flush    = 1'b0;
        bus.op_valid = 1'b0;
        bus.op       = OP_NONE;
        bus.a        = '0;
        bus.b        = '0;
        bus.rd_req   = 1'b0;
        bus.rd_sel   = 1'b0;
        step();
        step();
        clr_n = 1'b1;

        chk("rst_ready", 64'(bus.op_ready), 64'd1);
        chk("rst_busy",  64'(bus.busy),     64'd0);
        chk("rst_stall", 64'(bus.stall_req), 64'd0);
        chk("rst_hi",    64'(bus.hi),       64'd0);
        chk("rst_lo",    64'(bus.lo),       64'd0);
        chk("rst_done",  64'(bus.done),     64'd0);

        issue_mt(OP_MTHI, 32'hDEADBEEF);
        chk("mthi_hi",   64'(bus.hi),   64'hDEADBEEF);
        chk("mthi_done", 64'(bus.done), 64'd0);
        chk("mthi_busy", 64'(bus.busy), 64'd0);
        bus.rd_sel = 1'b1;
        #1 chk("rd_hi", 64'(bus.rd_data), 64'hDEADBEEF);
        issue_mt(OP_MTLO, 32'h00001234);
        chk("mtlo_lo", 64'(bus.lo), 64'h1234);
        bus.rd_sel = 1'b0;
        #1 chk("rd_lo", 64'(bus.rd_data), 64'h1234);

        // Flush in IDLE blocks acceptance
        bus.flush = 1'b1;
        issue_mt(OP_MTHI, 32'h0000AAAA);
        bus.flush = 1'b0;
        chk("flush_idle_hi", 64'(bus.hi), 64'hDEADBEEF);

        run_op("mult", OP_MULT, 32'hFFFFFFFD, 32'd7, lat, busy_n, stall_n);
        chk("mult_lat",  64'(lat),    64'd3);
        chk("mult_busy", 64'(busy_n), 64'd3);
        chk("mult_prod", {bus.hi, bus.lo}, 64'hFFFFFFFF_FFFFFFEB);
        step();
        chk("mult_done_once", 64'(bus.done), 64'd0);

        run_op("multu", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, busy_n, stall_n);
        chk("multu_prod", {bus.hi, bus.lo}, 64'hFFFFFFFE_00000001);
        run_op("mult_min", OP_MULT, 32'h80000000, 32'h80000000, lat, busy_n, stall_n);
        chk("mult_min_prod", {bus.hi, bus.lo}, 64'h40000000_00000000);

        run_op("divu", OP_DIVU, 32'd100, 32'd7, lat, busy_n, stall_n);
        chk("divu_lat", 64'(lat),          64'd33);
        chk("divu_lo",  64'(bus.lo),       64'd14);
        chk("divu_hi",  64'(bus.hi),       64'd2);
        chk("divu_dz",  64'(bus.div_zero), 64'd0);

        run_op("div_neg", OP_DIV, 32'hFFFFFFF9, 32'd2, lat, busy_n, stall_n);
        chk("div_neg_lo", 64'(bus.lo), 64'hFFFFFFFD);
        chk("div_neg_hi", 64'(bus.hi), 64'hFFFFFFFF);
        run_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, lat, busy_n, stall_n);
        chk("div_ovf_lo", 64'(bus.lo), 64'h80000000);
        chk("div_ovf_hi", 64'(bus.hi), 64'd0);
        run_op("div_negb", OP_DIV, 32'd7, 32'hFFFFFFFE, lat, busy_n, stall_n);
        chk("div_negb_lo", 64'(bus.lo), 64'hFFFFFFFD);
        chk("div_negb_hi", 64'(bus.hi), 64'd1);

        run_op("dz", OP_DIV, 32'd5, 32'd0, lat, busy_n, stall_n);
        chk("dz_lat",  64'(lat),          64'd0);
        chk("dz_lo",   64'(bus.lo),       64'hFFFFFFFF);
        chk("dz_hi",   64'(bus.hi),       64'd5);
        chk("dz_flag", 64'(bus.div_zero), 64'd1);
        chk("dz_busy", 64'(busy_n),       64'd0);
        step();
        chk("dz_done_once", 64'(bus.done),     64'd0);
        chk("dz_flag_once", 64'(bus.div_zero), 64'd0);
        run_op("dzu", OP_DIVU, 32'd9, 32'd0, lat, busy_n, stall_n);
        chk("dzu_hi", 64'(bus.hi), 64'd9);

        // Next op accepted in the done cycle
        run_op("b2b1", OP_MULTU, 32'd2, 32'd3, lat, busy_n, stall_n);
        chk("b2b1_lo", 64'(bus.lo), 64'd6);
        run_op("b2b2", OP_MULTU, 32'd4, 32'd5, lat, busy_n, stall_n);
        chk("b2b2_lat", 64'(lat),              64'd3);
        chk("b2b2_prod", {bus.hi, bus.lo}, 64'd20);

        bus.rd_req = 1'b1;
        run_op("stall", OP_DIVU, 32'd1000, 32'd3, lat, busy_n, stall_n);
        chk("stall_cycles", 64'(stall_n),       64'd33);
        chk("stall_release", 64'(bus.stall_req), 64'd0);
        chk("stall_lo", 64'(bus.lo), 64'd333);
        chk("stall_hi", 64'(bus.hi), 64'd1);

        // Flush at cycle 10 of a divide
        bus.op_valid = 1'b1;
        bus.op       = OP_DIVU;
        bus.a        = 32'd50;
        bus.b        = 32'd4;
        step();
        bus.op_valid = 1'b0;
        bus.op       = OP_NONE;
        repeat (9) step();
        chk("flush_pre_stall", 64'(bus.stall_req), 64'd1);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        chk("flush_busy",  64'(bus.busy),      64'd0);
        chk("flush_ready", 64'(bus.op_ready),  64'd1);
        chk("flush_stall", 64'(bus.stall_req), 64'd0);
        chk("flush_hold", {bus.hi, bus.lo}, {32'd1, 32'd333});
        cnt = 0;
        repeat (40) begin
            if (bus.done === 1'b1) cnt++;
            step();
        end
        chk("flush_no_done", 64'(cnt), 64'd0);
        bus.rd_req = 1'b0;

        // Reset in cycle 2 of a multiply
        issue_mt(OP_MTLO, 32'h00001234);
        bus.op_valid = 1'b1;
        bus.op       = OP_MULTU;
        bus.a        = 32'd5;
        bus.b        = 32'd6;
        step();
        bus.op_valid = 1'b0;
        bus.op       = OP_NONE;
        step();
        clr_n = 1'b0;
        step();
        clr_n = 1'b1;
        chk("mrst_hi",    64'(bus.hi),       64'd0);
        chk("mrst_lo",    64'(bus.lo),       64'd0);
        chk("mrst_ready", 64'(bus.op_ready), 64'd1);
        chk("mrst_busy",  64'(bus.busy),     64'd0);
        cnt = 0;
        repeat (6) begin
            if (bus.done === 1'b1) cnt++;
            step();
        end
        chk("mrst_no_done", 64'(cnt), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/cpu_ex_muldiv.md
CPU_EX_MULDIV -- requirements
Module: cpu_ex_muldiv

Interface
REQ-001 Parameter XLEN, default 32: operand and HI/LO width; legal range 8..64.
REQ-002 Parameter MUL_LAT, default 3: multiply latency in cycles; legal range 1..8.
REQ-003 One clock; reset is synchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 clr_n  in  1  synchronous active-low reset; reset when 0 at a rising edge.
REQ-006 flush  in  1  abort the in-flight operation (pipeline squash).
REQ-007 op_valid  in  1  operation request.
REQ-008 op  in  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; 7 behaves as NONE.
REQ-009 a  in  XLEN  operand A (dividend / MTHI / MTLO source).
REQ-010 b  in  XLEN  operand B (divisor).
REQ-011 op_ready  out  1  high only in IDLE; op accepted when op_valid && op_ready && !flush.
REQ-012 busy  out  1  high in MUL or DIV.
REQ-013 rd_req  in  1  EX stage reads HI/LO (MFHI/MFLO).
REQ-014 rd_sel  in  1  0 selects LO, 1 selects HI.
REQ-015 rd_data  out  XLEN  combinational: rd_sel ? hi : lo.
REQ-016 stall_req  out  1  combinational: rd_req && busy.
REQ-017 hi, lo  out  XLEN each  architectural HI/LO registers.
REQ-018 done  out  1  one-cycle pulse in the cycle after HI/LO are written by MULT/MULTU/DIV/DIVU.
REQ-019 div_zero  out  1  one-cycle pulse, coincident with done, for a divide by zero.

Function
REQ-020 States: IDLE, MUL, DIV; no other states reachable.
REQ-021 IDLE: accepted MTHI writes hi=a; accepted MTLO writes lo=a; both at the accepting edge; state stays IDLE; no done pulse.
REQ-022 IDLE: accepted MULT/MULTU captures a, b and enters MUL with a down-counter loaded with MUL_LAT-1.
REQ-023 MUL: {hi,lo} = full 2*XLEN product, signed (MULT) or unsigned (MULTU), written at the edge where the counter is 0; next state IDLE. hi/lo therefore update MUL_LAT edges after the accepting edge.
REQ-024 IDLE: accepted DIV/DIVU with b != 0 enters DIV.
REQ-025 DIV: restoring divide on magnitudes, one quotient bit per cycle, XLEN iteration cycles, then one sign-fixup cycle; hi/lo are written XLEN+1 edges after the accepting edge.
REQ-026 Signed divide: quotient negative iff sign(a) != sign(b); remainder takes the sign of a; lo = quotient, hi = remainder.
REQ-027 Signed overflow (a = most negative value, b = -1) uses the normal path; result lo = a, hi = 0.
REQ-028 Divide by zero (DIV or DIVU, b == 0): no DIV state; lo = all ones, hi = a at the accepting edge; done and div_zero pulse in the next cycle.
REQ-029 flush has priority over all other inputs. In MUL or DIV, state returns to IDLE at the next edge; hi/lo are unchanged; no done pulse. In IDLE, flush blocks acceptance.
REQ-030 op_valid while busy is ignored. The requester holds the request until op_ready.
REQ-031 rd_data reflects hi/lo combinationally, including a value written at the preceding edge.
REQ-032 The operation accepted in the cycle that done is high is legal and is processed normally.

Reset
REQ-033 clr_n=0 at an edge: state IDLE, hi=0, lo=0, counters 0, done=0, div_zero=0. Reset overrides flush and op_valid, including mid-operation.
REQ-034 Outputs after reset: op_ready=1, busy=0, stall_req=0.

Verification (XLEN=32, MUL_LAT=3)
REQ-035 MULT a=0xFFFFFFFD b=7 -> busy for 3 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFEB; done pulses once.
REQ-036 DIVU a=100 b=7 -> 33 cycles later lo=14, hi=2, done=1, div_zero=0.
REQ-037 DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-038 DIV a=5 b=0 -> next edge lo=0xFFFFFFFF, hi=5; done and div_zero pulse together.
REQ-039 DIVU issued, rd_req=1 held -> stall_req=1 until done; repeat with flush asserted at cycle 10 -> IDLE next edge, hi/lo hold prior values, no done pulse.
REQ-040 MTLO 0x1234 then MULTU, with clr_n=0 at cycle 2 of MUL -> hi=lo=0, op_ready=1, no done pulse.
